// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port 2 KB video RAM between the video generator's
// character fetch and the Z80 CPU. Video has priority. The CPU is stalled
// through cpu_wait_n until its access completes. After CPU_MAX_WAIT
// consecutive denied cycles the CPU takes the port.
//
// Ports
//   clk, resetn            system clock, asynchronous active-low reset
//   vid_req/vid_addr       video fetch request (held until vid_ack) and address
//   vid_ack                combinational grant to video for this cycle
//   vid_valid/vid_data     video read data, one cycle after vid_ack
//   cpu_rd/cpu_wr          decoded CPU strobes (level); both high means write
//   cpu_addr/cpu_wdata     CPU address and write data, sampled in the grant cycle
//   cpu_rdata              CPU read data, held until the next CPU read completes
//   cpu_done               one-cycle pulse after a CPU grant
//   cpu_wait_n             low while a CPU access is pending and not yet done
//   ram_addr/ram_we/
//   ram_wdata/ram_rdata    RAM primitive interface (read latency one cycle)
//
// Optional build macro
//   VRAM_ARB_STATS_EN      adds output vid_stall_cnt[15:0], a saturating
//                          count of cycles where video was denied.
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 8,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  vid_req,
  input  logic [ADDR_WIDTH-1:0] vid_addr,
  output logic                  vid_ack,
  output logic                  vid_valid,
  output logic [DATA_WIDTH-1:0] vid_data,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_wait_n,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]           vid_stall_cnt
`endif
);

  localparam logic [7:0] C_MAX_WAIT = 8'(CPU_MAX_WAIT);

  // Tag travelling with each RAM read so the returning data goes to the
  // requester that was granted one cycle earlier.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  owner_e                r_rd_owner;
  owner_e                w_rd_owner_next;
  logic                  r_served;
  logic                  w_served_next;
  logic [7:0]            r_wait_cnt;
  logic [7:0]            w_wait_cnt_next;
  logic                  r_cpu_done;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_vid_data;

  logic w_any_strobe;
  logic w_cpu_req;
  logic w_cpu_grant;
  logic w_cpu_wr_grant;
  logic w_cpu_rd_grant;
  logic w_vid_grant;

  // Grant decision. These terms feed state only; outputs are additionally
  // qualified by resetn below.
  assign w_any_strobe   = cpu_rd | cpu_wr;
  assign w_cpu_req      = w_any_strobe & ~r_served;
  assign w_cpu_grant    = w_cpu_req & (~vid_req | (r_wait_cnt == C_MAX_WAIT));
  assign w_cpu_wr_grant = w_cpu_grant & cpu_wr;
  assign w_cpu_rd_grant = w_cpu_grant & ~cpu_wr;
  assign w_vid_grant    = vid_req & ~w_cpu_grant;

  // Next-state logic.
  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_served_next   = r_served;
    w_wait_cnt_next = r_wait_cnt;
    w_rd_owner_next = OWN_NONE;

    // One access per strobe: served blocks re-arbitration until the Z80
    // releases both rd_n and wr_n. It is set at the grant edge so it is
    // already high in the cpu_done cycle.
    if (w_cpu_grant) begin
      w_served_next = 1'b1;
    end else if (!w_any_strobe) begin
      w_served_next = 1'b0;
    end

    if (w_cpu_grant || !w_cpu_req) begin
      w_wait_cnt_next = '0;
    end else if (r_wait_cnt != 8'hff) begin
      w_wait_cnt_next = r_wait_cnt + 8'd1;
    end

    if (w_cpu_rd_grant) begin
      w_rd_owner_next = OWN_CPU;
    end else if (w_vid_grant) begin
      w_rd_owner_next = OWN_VID;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_owner  <= OWN_NONE;
      r_served    <= 1'b0;
      r_wait_cnt  <= '0;
      r_cpu_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_vid_data  <= '0;
    end else begin
      r_rd_owner <= w_rd_owner_next;
      r_served   <= w_served_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_cpu_done <= w_cpu_grant;
      // Capture returning data so each side keeps its last value after the
      // delivery cycle.
      if (r_rd_owner == OWN_CPU) begin
        r_cpu_rdata <= ram_rdata;
      end
      if (r_rd_owner == OWN_VID) begin
        r_vid_data <= ram_rdata;
      end
    end
  end

  // Read data is delivered straight from the RAM in the cycle after the grant
  // and held from the capture registers afterwards.
  assign vid_valid = (r_rd_owner == OWN_VID);
  assign vid_data  = (r_rd_owner == OWN_VID) ? ram_rdata : r_vid_data;
  assign cpu_rdata = (r_rd_owner == OWN_CPU) ? ram_rdata : r_cpu_rdata;
  assign cpu_done  = r_cpu_done;

  // Combinational outputs are forced to their idle values while resetn is
  // low, so an access in flight is dropped at once and the Z80 is released.
  assign vid_ack    = resetn & w_vid_grant;
  assign cpu_wait_n = ~(resetn & w_cpu_req & ~r_cpu_done);
  assign ram_we     = resetn & w_cpu_wr_grant;
  assign ram_wdata  = (resetn & w_cpu_wr_grant) ? cpu_wdata : '0;

  always_comb begin
    ram_addr = '0;
    if (resetn) begin
      if (w_cpu_grant) begin
        ram_addr = cpu_addr;
      end else if (w_vid_grant) begin
        ram_addr = vid_addr;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [15:0] r_vid_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vid_stall_cnt <= '0;
    end else if (vid_req && !w_vid_grant && (r_vid_stall_cnt != 16'hffff)) begin
      r_vid_stall_cnt <= r_vid_stall_cnt + 16'd1;
    end
  end

  assign vid_stall_cnt = r_vid_stall_cnt;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Self-checking bench for vram_arbiter (built with CPU_MAX_WAIT = 4).
// A behavioural synchronous RAM sits on the RAM port. A shadow array holds the
// values the bench expects the RAM to contain; scenario tasks push expected
// read data into per-requester queues, and a monitor pops and compares them
// whenever vid_valid or cpu_done is seen.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic          vid_valid;
  logic [DW-1:0] vid_data;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;
  logic          cpu_wait_n;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   vid_stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          is_wr;
    logic [DW-1:0] data;
  } cpu_exp_t;

  logic [DW-1:0] vid_q[$];
  cpu_exp_t      cpu_q[$];

  logic [DW-1:0] ram_mem  [2**AW];
  logic [DW-1:0] model_mem[2**AW];

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .CPU_MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_valid (vid_valid),
    .vid_data  (vid_data),
    .cpu_rd    (cpu_rd),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_wait_n(cpu_wait_n),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .vid_stall_cnt(vid_stall_cnt)
`endif
  );

  // Behavioural single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Scoreboard monitor: compares delivered read data against the queues.
  always @(posedge clk) begin
    logic [DW-1:0] v_exp;
    cpu_exp_t      c_exp;
    #2;
    if (resetn) begin
      if (vid_valid) begin
        n_checks++;
        if (vid_q.size() == 0) begin
          n_errors++;
          $display("FAIL vid_unexpected: vid_valid with data %02h, none expected", vid_data);
        end else begin
          v_exp = vid_q.pop_front();
          if (vid_data !== v_exp) begin
            n_errors++;
            $display("FAIL vid_data: got %02h want %02h", vid_data, v_exp);
          end
        end
      end
      if (cpu_done) begin
        n_checks++;
        if (cpu_q.size() == 0) begin
          n_errors++;
          $display("FAIL cpu_unexpected: cpu_done with none expected");
        end else begin
          c_exp = cpu_q.pop_front();
          if (!c_exp.is_wr && (cpu_rdata !== c_exp.data)) begin
            n_errors++;
            $display("FAIL cpu_rdata: got %02h want %02h", cpu_rdata, c_exp.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    resetn = 1'b0; vid_req = 1'b1; vid_addr = 11'h7ff;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'h3ff; cpu_wdata = 8'h00;
    #3;
    n_checks++; if (vid_valid !== 1'b0) begin n_errors++; $display("FAIL reset_vid_valid: got %b want 0", vid_valid); end
    n_checks++; if (vid_data !== 8'h00) begin n_errors++; $display("FAIL reset_vid_data: got %02h want 00", vid_data); end
    n_checks++; if (cpu_done !== 1'b0) begin n_errors++; $display("FAIL reset_cpu_done: got %b want 0", cpu_done); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_cpu_rdata: got %02h want 00", cpu_rdata); end
    n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL reset_cpu_wait_n: got %b want 1", cpu_wait_n); end
    n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_checks++; if (ram_addr !== 11'h000) begin n_errors++; $display("FAIL reset_ram_addr: got %03h want 000", ram_addr); end
    n_checks++; if (vid_ack !== 1'b0) begin n_errors++; $display("FAIL reset_vid_ack: got %b want 0", vid_ack); end
    @(negedge clk);
    vid_req = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; vid_addr = '0;
    resetn = 1'b1;
  endtask

  task automatic test_video_only();
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 11'h005;
    #1;
    n_checks++; if (vid_ack !== 1'b1) begin n_errors++; $display("FAIL vo_ack: got %b want 1", vid_ack); end
    n_checks++; if (ram_addr !== 11'h005) begin n_errors++; $display("FAIL vo_ram_addr: got %03h want 005", ram_addr); end
    n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL vo_wait_n: got %b want 1", cpu_wait_n); end
    vid_q.push_back(model_mem[11'h005]);
    @(negedge clk);
    vid_req = 1'b0;
    #1;
    n_checks++; if (vid_valid !== 1'b1) begin n_errors++; $display("FAIL vo_valid: got %b want 1", vid_valid); end
    n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL vo_wait_n2: got %b want 1", cpu_wait_n); end
    @(negedge clk);
    #1;
    n_checks++; if (vid_valid !== 1'b0) begin n_errors++; $display("FAIL vo_valid_drop: got %b want 0", vid_valid); end
  endtask

  task automatic test_cpu_write();
    logic [AW-1:0] wa[2];
    logic [DW-1:0] wd[2];
    logic          both[2];
    wa[0] = 11'h123; wd[0] = 8'h5a; both[0] = 1'b0;
    wa[1] = 11'h200; wd[1] = 8'hc3; both[1] = 1'b1;   // rd and wr together
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cpu_wr = 1'b1; cpu_rd = both[i]; cpu_addr = wa[i]; cpu_wdata = wd[i];
      #1;
      n_checks++; if (ram_we !== 1'b1) begin n_errors++; $display("FAIL wr%0d_ram_we: got %b want 1", i, ram_we); end
      n_checks++; if (ram_addr !== wa[i]) begin n_errors++; $display("FAIL wr%0d_ram_addr: got %03h want %03h", i, ram_addr, wa[i]); end
      n_checks++; if (ram_wdata !== wd[i]) begin n_errors++; $display("FAIL wr%0d_ram_wdata: got %02h want %02h", i, ram_wdata, wd[i]); end
      n_checks++; if (cpu_wait_n !== 1'b0) begin n_errors++; $display("FAIL wr%0d_wait_n: got %b want 0", i, cpu_wait_n); end
      model_mem[wa[i]] = wd[i];
      cpu_q.push_back('{is_wr: 1'b1, data: '0});
      @(negedge clk);
      #1;
      n_checks++; if (cpu_done !== 1'b1) begin n_errors++; $display("FAIL wr%0d_done: got %b want 1", i, cpu_done); end
      n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL wr%0d_wait_n_rise: got %b want 1", i, cpu_wait_n); end
      n_checks++; if (ram_we !== 1'b0) begin n_errors++; $display("FAIL wr%0d_we_once: got %b want 0", i, ram_we); end
      @(negedge clk);
      cpu_wr = 1'b0; cpu_rd = 1'b0;
      #1;
      n_checks++; if (cpu_done !== 1'b0) begin n_errors++; $display("FAIL wr%0d_done_pulse: got %b want 0", i, cpu_done); end
    end
    // Read both locations back.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cpu_rd = 1'b1; cpu_addr = wa[i];
      #1;
      n_checks++; if (ram_we !== 1'b0 || ram_addr !== wa[i]) begin n_errors++; $display("FAIL rb%0d_ram: got we=%b addr=%03h want we=0 addr=%03h", i, ram_we, ram_addr, wa[i]); end
      cpu_q.push_back('{is_wr: 1'b0, data: model_mem[wa[i]]});
      @(negedge clk);
      #1;
      n_checks++; if (cpu_done !== 1'b1) begin n_errors++; $display("FAIL rb%0d_done: got %b want 1", i, cpu_done); end
      @(negedge clk);
      cpu_rd = 1'b0;
    end
  endtask

  task automatic test_held_strobe();
    int n_done = 0;
    int n_rd   = 0;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 11'h040;
    cpu_q.push_back('{is_wr: 1'b0, data: model_mem[11'h040]});
    for (int c = 0; c < 6; c++) begin
      #1;
      if (cpu_done === 1'b1) n_done++;
      if (ram_addr !== 11'h000 || ram_we !== 1'b0) n_rd++;
      if (c == 2) cpu_addr = 11'h041;   // post-grant change must be ignored
      @(negedge clk);
    end
    cpu_rd = 1'b0;
    #1;
    n_checks++; if (n_done != 1) begin n_errors++; $display("FAIL held_done_count: got %0d want 1", n_done); end
    n_checks++; if (n_rd != 1) begin n_errors++; $display("FAIL held_ram_reads: got %0d want 1", n_rd); end
    n_checks++; if (cpu_rdata !== model_mem[11'h040]) begin n_errors++; $display("FAIL held_rdata_hold: got %02h want %02h", cpu_rdata, model_mem[11'h040]); end
    @(negedge clk);
    cpu_rd = 1'b1;
    #1;
    n_checks++; if (ram_addr !== 11'h041 || cpu_wait_n !== 1'b0) begin n_errors++; $display("FAIL held_second_grant: got addr=%03h wait_n=%b want addr=041 wait_n=0", ram_addr, cpu_wait_n); end
    cpu_q.push_back('{is_wr: 1'b0, data: model_mem[11'h041]});
    @(negedge clk);
    #1;
    n_checks++; if (cpu_done !== 1'b1) begin n_errors++; $display("FAIL held_second_done: got %b want 1", cpu_done); end
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_cpu_grant;
    logic exp_done;
    logic exp_wait_n;
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 11'h100;
    cpu_rd = 1'b1; cpu_addr = 11'h010;
    for (int c = 0; c < 13; c++) begin
      exp_cpu_grant = (c == MAX_WAIT) || (c == MAX_WAIT + 7);
      exp_done      = (c == MAX_WAIT + 1) || (c == MAX_WAIT + 8);
      exp_wait_n    = !((c <= MAX_WAIT) || (c >= 7 && c <= MAX_WAIT + 7));
      #1;
      n_checks++; if (vid_ack !== !exp_cpu_grant) begin n_errors++; $display("FAIL cont_c%0d_vid_ack: got %b want %b", c, vid_ack, !exp_cpu_grant); end
      n_checks++; if (cpu_wait_n !== exp_wait_n) begin n_errors++; $display("FAIL cont_c%0d_wait_n: got %b want %b", c, cpu_wait_n, exp_wait_n); end
      n_checks++; if (cpu_done !== exp_done) begin n_errors++; $display("FAIL cont_c%0d_done: got %b want %b", c, cpu_done, exp_done); end
      if (exp_cpu_grant) begin
        n_checks++; if (ram_addr !== cpu_addr) begin n_errors++; $display("FAIL cont_c%0d_ram_addr: got %03h want %03h", c, ram_addr, cpu_addr); end
        cpu_q.push_back('{is_wr: 1'b0, data: model_mem[cpu_addr]});
      end else begin
        vid_q.push_back(model_mem[vid_addr]);
      end
      @(negedge clk);
      if (!exp_cpu_grant) vid_addr = vid_addr + 11'd1;
      // Drop the strobe for one cycle, then raise a new access.
      cpu_rd   = (c != 5);
      if (c == 6) cpu_addr = 11'h011;
    end
    vid_req = 1'b0; cpu_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternating();
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 11'h001;
    #1;
    n_checks++; if (vid_ack !== 1'b1) begin n_errors++; $display("FAIL alt_vid_ack: got %b want 1", vid_ack); end
    vid_q.push_back(model_mem[11'h001]);
    @(negedge clk);
    vid_req = 1'b0; cpu_rd = 1'b1; cpu_addr = 11'h002;
    #1;
    n_checks++; if (vid_ack !== 1'b0 || ram_addr !== 11'h002) begin n_errors++; $display("FAIL alt_cpu_grant: got ack=%b addr=%03h want ack=0 addr=002", vid_ack, ram_addr); end
    n_checks++; if (vid_valid !== 1'b1 || cpu_done !== 1'b0) begin n_errors++; $display("FAIL alt_vid_owner: got valid=%b done=%b want valid=1 done=0", vid_valid, cpu_done); end
    cpu_q.push_back('{is_wr: 1'b0, data: model_mem[11'h002]});
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 11'h003;
    #1;
    n_checks++; if (cpu_done !== 1'b1 || vid_valid !== 1'b0) begin n_errors++; $display("FAIL alt_cpu_owner: got done=%b valid=%b want done=1 valid=0", cpu_done, vid_valid); end
    n_checks++; if (vid_ack !== 1'b1) begin n_errors++; $display("FAIL alt_vid_ack2: got %b want 1", vid_ack); end
    vid_q.push_back(model_mem[11'h003]);
    @(negedge clk);
    vid_req = 1'b0; cpu_rd = 1'b0;
    #1;
    n_checks++; if (vid_valid !== 1'b1 || cpu_done !== 1'b0) begin n_errors++; $display("FAIL alt_vid_owner2: got valid=%b done=%b want valid=1 done=0", vid_valid, cpu_done); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 11'h020;
    #1;
    n_checks++; if (ram_addr !== 11'h020 || cpu_wait_n !== 1'b0) begin n_errors++; $display("FAIL rst_grant: got addr=%03h wait_n=%b want addr=020 wait_n=0", ram_addr, cpu_wait_n); end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++; if (cpu_wait_n !== 1'b1) begin n_errors++; $display("FAIL rst_wait_n: got %b want 1", cpu_wait_n); end
    n_checks++; if (ram_addr !== 11'h000 || ram_we !== 1'b0) begin n_errors++; $display("FAIL rst_ram: got addr=%03h we=%b want addr=000 we=0", ram_addr, ram_we); end
    n_checks++; if (cpu_rdata !== 8'h00) begin n_errors++; $display("FAIL rst_rdata: got %02h want 00", cpu_rdata); end
    @(posedge clk);
    #2;
    n_checks++; if (cpu_done !== 1'b0 || vid_valid !== 1'b0) begin n_errors++; $display("FAIL rst_no_pulse: got done=%b valid=%b want 0 0", cpu_done, vid_valid); end
    @(negedge clk);
    cpu_rd = 1'b0; resetn = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b1;
    #1;
    n_checks++; if (cpu_wait_n !== 1'b0 || ram_addr !== 11'h020) begin n_errors++; $display("FAIL rst_regrant: got wait_n=%b addr=%03h want 0 020", cpu_wait_n, ram_addr); end
    cpu_q.push_back('{is_wr: 1'b0, data: model_mem[11'h020]});
    @(negedge clk);
    #1;
    n_checks++; if (cpu_done !== 1'b1) begin n_errors++; $display("FAIL rst_regrant_done: got %b want 1", cpu_done); end
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ram_mem[i]   = 8'((i * 37) + 11);
      model_mem[i] = 8'((i * 37) + 11);
    end
    ram_mem[5]   = 8'h41;
    model_mem[5] = 8'h41;

    test_reset();
    test_video_only();
    test_cpu_write();
    test_held_strobe();
    test_contention();
    test_alternating();
    test_reset_mid_read();

    repeat (3) @(negedge clk);
    n_checks++; if (vid_q.size() != 0) begin n_errors++; $display("FAIL vid_q_drain: got %0d pending want 0", vid_q.size()); end
    n_checks++; if (cpu_q.size() != 0) begin n_errors++; $display("FAIL cpu_q_drain: got %0d pending want 0", cpu_q.size()); end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port 2 KB video RAM (0x2800-0x2fff) between the video generator's character fetch and Z80 CPU reads and writes.
- Video has priority by default. The CPU is stalled through its wait_n input until it is served.
- A starvation guard gives the CPU the port after a bounded wait.
- Sits between tv80n, the video generator and the RAM primitive, all in the clk domain.

Parameters:
- ADDR_WIDTH, 11, RAM address width (2 KB).
- DATA_WIDTH, 8, RAM data width.
- CPU_MAX_WAIT, 16, number of consecutive denied CPU cycles after which the CPU wins. Legal range 1..255.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- vid_req  input  1  video fetch request; held high until vid_ack.
- vid_addr  input  ADDR_WIDTH  video fetch address.
- vid_ack  output  1  combinational; video request granted this cycle.
- vid_valid  output  1  registered; vid_data is valid, one cycle after vid_ack.
- vid_data  output  DATA_WIDTH  video read data.
- cpu_rd  input  1  CPU read strobe (decoded ~rd_n & ~mreq_n & address hit), level.
- cpu_wr  input  1  CPU write strobe, level.
- cpu_addr  input  ADDR_WIDTH  CPU address.
- cpu_wdata  input  DATA_WIDTH  CPU write data.
- cpu_rdata  output  DATA_WIDTH  CPU read data, held until the next CPU read completes.
- cpu_done  output  1  registered one-cycle pulse; CPU access completed.
- cpu_wait_n  output  1  low while a CPU access is pending and not yet done.
- ram_addr  output  ADDR_WIDTH  RAM address (combinational mux).
- ram_we  output  1  RAM write enable (combinational).
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  RAM synchronous read data, one-cycle latency.

Behaviour:
- Reset values: vid_valid=0, vid_data=0, cpu_done=0, cpu_rdata=0, cpu_wait_n=1, ram_we=0, ram_addr=0. Internal state: served=0, wait_cnt=0, rd_owner=NONE.
- cpu_req = (cpu_rd | cpu_wr) & ~served.
- Grant is decided each cycle:
  - CPU wins if cpu_req & (~vid_req | wait_cnt == CPU_MAX_WAIT).
  - Otherwise video wins if vid_req.
  - Otherwise idle.
- Video grant:
  - vid_ack=1, ram_addr=vid_addr, ram_we=0.
  - Next cycle: vid_valid=1, vid_data=ram_rdata.
- CPU write grant: ram_addr=cpu_addr, ram_we=1, ram_wdata=cpu_wdata. cpu_done pulses the next cycle.
- CPU read grant: ram_addr=cpu_addr, ram_we=0. Next cycle: cpu_rdata=ram_rdata, cpu_done=1.
- cpu_rd & cpu_wr both high: treated as a write.
- served is set in the cpu_done cycle and cleared when cpu_rd and cpu_wr are both low. One access per strobe; no double service while the Z80 holds rd_n or wr_n.
- cpu_wait_n = ~(cpu_req & ~cpu_done). It rises in the cpu_done cycle. Minimum stall is 1 cycle; maximum is CPU_MAX_WAIT+1 cycles.
- wait_cnt:
  - Increments (saturating at 255) each cycle cpu_req is denied.
  - Clears on CPU grant or when cpu_req is low.
- rd_owner pipeline register tags which requester gets the returning read data. Back-to-back grants to alternating owners are legal every cycle.
- Video denied (vid_ack=0 while vid_req=1): the video generator must hold its request. No data is lost.
- cpu_addr and cpu_wdata are sampled only in the grant cycle; changes after the grant are ignored.
- Asynchronous reset mid-access: the pending read is discarded, no vid_valid or cpu_done pulse occurs, and all state returns to reset values.

Optional Feature:
- Macro: VRAM_ARB_STATS_EN.
- Defined: adds output vid_stall_cnt [15:0].
  - Increments every cycle vid_req=1 & vid_ack=0.
  - Saturates at 0xffff; cleared by resetn.
- Undefined: the port and counter are absent; arbitration is identical.

Test Plan:
- Video only: vid_req=1, vid_addr=0x005, RAM[0x005]=0x41 -> vid_ack same cycle; vid_valid=1 and vid_data=0x41 next cycle; cpu_wait_n stays 1.
- CPU write with video idle: cpu_wr=1, addr=0x123, data=0x5A -> ram_we=1 for one cycle; cpu_done pulses next cycle; cpu_wait_n low exactly 1 cycle. A later read of 0x123 returns 0x5A.
- Held strobe: cpu_rd held for 6 cycles -> exactly one cpu_done and one RAM read. Dropping cpu_rd then raising it again -> a second access.
- Contention, CPU_MAX_WAIT=4, vid_req continuously high, cpu_rd at 0x010 -> video acked 4 cycles, then CPU granted on the 5th cycle (vid_ack=0); cpu_done the cycle after; wait_cnt back to 0.
- Alternating grants: video addr 0x001, then CPU read addr 0x002, on consecutive cycles -> vid_data=RAM[1] and cpu_rdata=RAM[2] on the respective next cycles; no cross-delivery.
- Reset mid-read: assert resetn=0 in the CPU read grant cycle -> no cpu_done; cpu_wait_n=1 and all outputs at reset values immediately.
